// File: rtl/hms_display_driver_pkg.sv
// hms_disp_pkg: segment codes, digit index type, field limits and the time payload
// shared by the HH.MM.SS display driver and its time interface.
package hms_disp_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef logic [2:0] digit_idx_t;
  localparam digit_idx_t LAST_DIGIT = 3'd5;

  localparam logic [5:0] ANODES_OFF = 6'b111111;

  localparam logic [5:0] MAX_HOURS = 6'd23;
  localparam logic [5:0] MAX_MINS  = 6'd59;
  localparam logic [5:0] MAX_SECS  = 6'd59;

  // Per-frame time snapshot
  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] mins;
    logic [5:0] secs;
  } hms_time_t;

  // BCD digit to segment pattern; anything above 9 renders as a dash
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hms_display_driver_if.sv
// hms_display_driver_if: time/alarm signals from the clock core to the display driver.
interface hms_display_driver_if;
  logic [4:0] hours;
  logic [5:0] mins;
  logic [5:0] secs;
  logic       buzzer;

  modport master (output hours, output mins, output secs, output buzzer);
  modport slave  (input  hours, input  mins, input  secs, input  buzzer);
endinterface

// File: rtl/hms_display_driver_bin2bcd_2d.sv
// bin2bcd_2d: combinational split of a 0..63 value into two BCD digits plus an over-limit flag.
module bin2bcd_2d (
  input  logic [5:0] value,
  input  logic [5:0] limit,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       over
);

  // Constant divide/modulo by ten on a 6-bit value
  always_comb begin
    tens = 4'(value / 6'd10);
    ones = 4'(value % 6'd10);
    over = value > limit;
  end

endmodule

// File: rtl/hms_display_driver.sv
// hms_display_driver: snapshots HH.MM.SS once per frame and scans it onto a 6-digit
// common-anode seven-segment display, flashing the display while the buzzer is on.
// Build option: HMS_LEADING_ZERO_BLANK_EN blanks the hours tens digit when hours < 10.
module hms_display_driver
  import hms_disp_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLINK_CYCLES = 25000000
) (
  input  logic                       clk,
  input  logic                       reset,
  hms_display_driver_if.slave        tm,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic [5:0]                 an,
  output logic                       frame_done
);

  localparam int unsigned SCAN_W  = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [SCAN_W-1:0]  scan_cnt;
  digit_idx_t         idx;
  hms_time_t          snap;
  logic               scan_last_c;

  digit_idx_t         stg_idx;
  logic               stg_last;
  logic               stg_vld;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  logic [3:0]         s_tens, s_ones, m_tens, m_ones, h_tens, h_ones;
  logic               s_over, m_over, h_over;

  logic [3:0]         digit_c;
  logic               over_c;
  logic               blank_c;
  logic [5:0]         an_c;
  logic [6:0]         seg_c;
  logic               dp_c;
  logic               fd_c;

  assign scan_last_c = (scan_cnt == SCAN_W'(DIGIT_CYCLES - 1));

  // Scan counter, digit index and the frame-start snapshot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      idx      <= '0;
      snap     <= '0;
    end else begin
      if (scan_last_c) begin
        scan_cnt <= '0;
        idx      <= (idx == LAST_DIGIT) ? digit_idx_t'(0) : idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      if (scan_cnt == '0 && idx == '0) begin
        snap <= '{hours: tm.hours, mins: tm.mins, secs: tm.secs};
      end
    end
  end

  // Index stage: lines the digit slot up with the snapshot it must display
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_idx  <= '0;
      stg_last <= 1'b0;
      stg_vld  <= 1'b0;
    end else begin
      stg_idx  <= idx;
      stg_last <= scan_last_c && (idx == LAST_DIGIT);
      stg_vld  <= 1'b1;
    end
  end

  // Blink half-period timer; idle and cleared whenever the buzzer is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!tm.buzzer) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BLINK_W'(1);
    end
  end

  bin2bcd_2d u_secs  (.value(snap.secs),        .limit(MAX_SECS),  .tens(s_tens), .ones(s_ones), .over(s_over));
  bin2bcd_2d u_mins  (.value(snap.mins),        .limit(MAX_MINS),  .tens(m_tens), .ones(m_ones), .over(m_over));
  bin2bcd_2d u_hours (.value(6'(snap.hours)),   .limit(MAX_HOURS), .tens(h_tens), .ones(h_ones), .over(h_over));

`ifdef HMS_LEADING_ZERO_BLANK_EN
  assign blank_c = (stg_idx == LAST_DIGIT) && (snap.hours < 5'd10);
`else
  assign blank_c = 1'b0;
`endif

  // Select the BCD digit and its field's range flag for the current slot
  always_comb begin
    digit_c = s_ones;
    over_c  = s_over;
    case (stg_idx)
      3'd0:    begin digit_c = s_ones; over_c = s_over; end
      3'd1:    begin digit_c = s_tens; over_c = s_over; end
      3'd2:    begin digit_c = m_ones; over_c = m_over; end
      3'd3:    begin digit_c = m_tens; over_c = m_over; end
      3'd4:    begin digit_c = h_ones; over_c = h_over; end
      default: begin digit_c = h_tens; over_c = h_over; end
    endcase
  end

  // Next pin values; dark until the index stage holds a real slot
  always_comb begin
    an_c  = ANODES_OFF;
    seg_c = SEG_OFF;
    dp_c  = 1'b1;
    fd_c  = 1'b0;
    if (stg_vld) begin
      an_c  = ~(6'(1) << stg_idx);
      seg_c = over_c ? SEG_DASH : seg_of(digit_c);
      dp_c  = !(stg_idx == 3'd2 || stg_idx == 3'd4);
      fd_c  = stg_last;
      if (blank_c) begin
        an_c  = ANODES_OFF;
        seg_c = SEG_OFF;
      end
      // Gating with the live buzzer lets the display return on the first update after release
      if (blink_phase && tm.buzzer) begin
        an_c = ANODES_OFF;
      end
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an         <= ANODES_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_c;
      seg        <= seg_c;
      dp         <= dp_c;
      frame_done <= fd_c;
    end
  end

endmodule

// File: doc/hms_display_driver.md
Name: hms_display_driver

Overview:
- Reader/consumer end of the clock's time interface: takes hours/mins/secs/buzzer from the clock core and drives a 6-digit multiplexed common-anode seven-segment display (HH.MM.SS).
- Takes a per-frame snapshot of the time, converts each field to two BCD digits, and scans the digits one at a time.
- Flashes the whole display while the alarm buzzer is asserted.
- Sits between the clock core and the board I/O pins.

Parameters:
- DIGIT_CYCLES, default 50000: clk cycles each digit stays lit (≥2).
- BLINK_CYCLES, default 25000000: clk cycles per blink half-period while the buzzer is asserted (≥2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- hours  in  5  binary hours, valid range 0..23
- mins  in  6  binary minutes, valid range 0..59
- secs  in  6  binary seconds, valid range 0..59
- buzzer  in  1  alarm active
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- an  out  6  digit enables, active-low, one-hot-low; an[0] = secs ones … an[5] = hours tens
- frame_done  out  1  one-cycle pulse on the last cycle of digit 5

Behaviour:
- Reset (async assert, sync release):
  - an=6'b111111, seg=7'b1111111, dp=1, frame_done=0.
  - Scan counter=0, digit index=0, blink phase=0, blink counter=0, snapshot=0.
- Scan counter counts 0..DIGIT_CYCLES-1. At terminal count it returns to 0 and the digit index advances 0→1→…→5→0.
- Snapshot: hours/mins/secs are latched when scan counter==0 and index==0. This includes the first cycle after reset release.
  - Input changes mid-frame are not shown until the next frame (no tearing).
- Output timing:
  - All outputs are registered; there is 1-cycle latency from the index/counter state to an/seg/dp.
  - The first digit appears on the 2nd clk edge after reset release.
- Digit mapping: idx0=secs%10, idx1=secs/10, idx2=mins%10, idx3=mins/10, idx4=hours%10, idx5=hours/10.
- Segment codes (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111
- Out-of-range fields show dash on both of their digits: hours>23, or mins>59, or secs>59.
- dp=0 on idx2 and idx4 (separators); dp=1 otherwise.
- frame_done=1 for exactly one cycle, aligned with the last cycle of idx5 on an (i.e. registered alongside it).
- Blink:
  - While buzzer=1, the blink counter runs 0..BLINK_CYCLES-1 and toggles the phase at terminal count.
  - Phase=1 forces an=6'b111111. Scanning and the snapshot continue underneath.
  - buzzer 1→0 clears the phase and the counter in the same cycle; the display is active on the next output update.
  - buzzer is sampled synchronously; a 1-cycle buzzer pulse starts the counter with no visible effect unless it is held.
- Reset mid-operation: outputs go to their reset values immediately (async) and the scan restarts at idx0 with a fresh snapshot.

Optional Feature:
- Macro: HMS_LEADING_ZERO_BLANK_EN
- Defined: when snapshot hours<10, idx5 is blanked:
  - an stays all-high for that digit's slot and seg=1111111.
  - Timing and frame_done are unchanged.
- Undefined: hours tens always displays, including "0".

Decomposition:
- Package hms_disp_pkg:
  - segment code constants SEG_0..SEG_9, SEG_DASH, SEG_OFF
  - 3-bit digit index typedef
  - ANODES_OFF constant
  - field limits MAX_HOURS=23, MAX_MINS=59, MAX_SECS=59
- One sub-module: bin2bcd_2d. Input is a 6-bit value and a limit; outputs are tens[3:0], ones[3:0] and an over-range flag. It is combinational and instantiated three times on the snapshot.

Test Plan (DIGIT_CYCLES=4, BLINK_CYCLES=8):
1. Apply hours=1, mins=3, secs=2 and release reset. Expected frame:
   - an=111110 seg=0100100 for 4 cycles
   - then 111101/1000000
   - then 111011/0110000 with dp=0
   - then 110111/1000000
   - then 101111/1111001 with dp=0
   - then 011111/1000000
   - frame_done pulses every 24 cycles.
2. Change secs 2→7 during idx3 → remainder of the frame unchanged; next frame idx0 shows 1111000.
3. Set mins=60 → idx2 and idx3 show 0111111; idx0, 1, 4 and 5 are unaffected.
4. Hold buzzer=1 for 40 cycles → an alternates all-high 8 cycles and scanning 8 cycles. When buzzer drops during a dark phase, the next an update is a lit digit.
5. Assert reset mid-idx3 → an=111111 and seg=1111111 in the same cycle without waiting for a clk edge; after release the scan restarts at idx0.
6. Time 23:59:59→00:00:00 across frames → the next frame shows all-zero digits. With HMS_LEADING_ZERO_BLANK_EN defined, the idx5 slot has an=111111; hours=23 still shows "2" in idx5.
